bsg_manycore_drlp_lane_ctrl: RTL and testbench



---
 rtl/bsg_manycore_drlp_pkg.sv | 8 +
 rtl/bsg_manycore_drlp_lane_tracker.sv | 34 +++
 rtl/bsg_manycore_drlp_lane_ctrl.sv | 127 ++++++++++++
 tb/tb_bsg_manycore_drlp_lane_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_drlp_pkg.sv
// Shared types and constants for the DRLP slave lane controller.
package bsg_manycore_drlp_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} drlp_lane_state_e;

   localparam int drlp_perf_width_gp = 32;

endpackage

// File: rtl/bsg_manycore_drlp_lane_tracker.sv
// Sticky per-lane PE-valid tracker with a registered all-lanes-ready flag.
// clear has priority over en; valids are only accumulated while en is high.
module bsg_manycore_drlp_lane_tracker #(
   parameter int num_lanes_p = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   en,
   input  logic [num_lanes_p-1:0] mask,
   input  logic [num_lanes_p-1:0] data_v,
   output logic                   ready
);

   logic [num_lanes_p-1:0] sticky_r;
   logic [num_lanes_p-1:0] sticky_n;

   assign sticky_n = sticky_r | (data_v & mask);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_r <= '0;
         ready    <= 1'b0;
      end else if (clear) begin
         sticky_r <= '0;
         ready    <= 1'b0;
      end else if (en) begin
         sticky_r <= sticky_n;
         if (sticky_n == mask)
            ready <= 1'b1;
      end
   end

endmodule

// File: rtl/bsg_manycore_drlp_lane_ctrl.sv
// DRLP slave lane controller: per-lane weight load, PE-valid tracking, layer done.
// Optional RUN-cycle counter is built only when BSG_MANYCORE_DRLP_PERF_EN is defined.
module bsg_manycore_drlp_lane_ctrl
   import bsg_manycore_drlp_pkg::*;
#(
   parameter int num_lanes_p       = 16,
   parameter int imem_addr_width_p = 13
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          sld_i,
   input  logic                          dw_wgt_start_i,
   input  logic [num_lanes_p-1:0]        lane_mask_i,
   input  logic [imem_addr_width_p-1:0]  end_addr_i,
   input  logic [imem_addr_width_p-1:0]  imem_r_addr_i,
   input  logic [num_lanes_p-1:0]        pe_data_v_i,
   output logic [num_lanes_p-1:0]        wgt_we_o,
   output logic                          busy_o,
   output logic                          all_pe_ready_o,
   output logic                          all_slave_done_o,
   output logic [drlp_perf_width_gp-1:0] run_cycles_o
);

   localparam int ptr_w = $clog2(num_lanes_p);
   localparam logic [ptr_w-1:0] last_lane = ptr_w'(num_lanes_p - 1);

   drlp_lane_state_e state_r, state_n;
   logic [ptr_w-1:0]             lane_ptr_r, lane_ptr_n;
   logic [num_lanes_p-1:0]       mask_r, mask_n;
   logic                         mode_r, mode_n;
   logic [imem_addr_width_p-1:0] end_r, end_n;
   logic [num_lanes_p-1:0]       wgt_we_n;
   logic                         trk_clear;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r    <= IDLE;
         lane_ptr_r <= '0;
         mask_r     <= '0;
         mode_r     <= 1'b0;
         end_r      <= '0;
         wgt_we_o   <= '0;
      end else begin
         state_r    <= state_n;
         lane_ptr_r <= lane_ptr_n;
         mask_r     <= mask_n;
         mode_r     <= mode_n;
         end_r      <= end_n;
         wgt_we_o   <= wgt_we_n;
      end
   end

   // sld_i is honoured in every state and always takes priority over completion.
   always_comb begin
      state_n    = state_r;
      lane_ptr_n = lane_ptr_r;
      mask_n     = mask_r;
      mode_n     = mode_r;
      end_n      = end_r;
      if (sld_i) begin
         mask_n     = lane_mask_i;
         mode_n     = dw_wgt_start_i;
         end_n      = end_addr_i;
         lane_ptr_n = '0;
         state_n    = (lane_mask_i == '0) ? DONE : LOAD;
      end else begin
         case (state_r)
            LOAD: begin
               if (mode_r) begin
                  state_n = RUN;
               end else if (lane_ptr_r == last_lane) begin
                  lane_ptr_n = '0;
                  state_n    = RUN;
               end else begin
                  lane_ptr_n = lane_ptr_r + ptr_w'(1);
               end
            end
            RUN: begin
               if (all_pe_ready_o && (imem_r_addr_i == end_r))
                  state_n = DONE;
            end
            default: state_n = state_r;
         endcase
      end
   end

   // Strobes are registered, so they are computed from the next state.
   always_comb begin
      wgt_we_n = '0;
      if (state_n == LOAD)
         wgt_we_n = mode_n ? mask_n : ((num_lanes_p'(1) << lane_ptr_n) & mask_n);
      busy_o           = (state_r == LOAD) || (state_r == RUN);
      all_slave_done_o = (state_r == DONE);
   end

   assign trk_clear = (state_n != RUN);

   bsg_manycore_drlp_lane_tracker #(
      .num_lanes_p(num_lanes_p)
   ) tracker (
      .clk    (clk_i),
      .rst    (reset_i),
      .clear  (trk_clear),
      .en     (state_r == RUN),
      .mask   (mask_r),
      .data_v (pe_data_v_i),
      .ready  (all_pe_ready_o)
   );

`ifdef BSG_MANYCORE_DRLP_PERF_EN
   logic [drlp_perf_width_gp-1:0] run_cnt_r;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         run_cnt_r <= '0;
      else if (sld_i)
         run_cnt_r <= '0;
      else if ((state_r == RUN) && (run_cnt_r != '1))
         run_cnt_r <= run_cnt_r + drlp_perf_width_gp'(1);
   end

   assign run_cycles_o = run_cnt_r;
`else
   assign run_cycles_o = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_drlp_lane_ctrl.sv
// Directed bench for bsg_manycore_drlp_lane_ctrl with four lanes.
module tb_bsg_manycore_drlp_lane_ctrl;

   localparam int nl = 4;
   localparam int aw = 13;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          sld_i;
   logic          dw_wgt_start_i;
   logic [nl-1:0] lane_mask_i;
   logic [aw-1:0] end_addr_i;
   logic [aw-1:0] imem_r_addr_i;
   logic [nl-1:0] pe_data_v_i;
   logic [nl-1:0] wgt_we_o;
   logic          busy_o;
   logic          all_pe_ready_o;
   logic          all_slave_done_o;
   logic [31:0]   run_cycles_o;

   int checks   = 0;
   int failures = 0;

   bsg_manycore_drlp_lane_ctrl #(
      .num_lanes_p       (nl),
      .imem_addr_width_p (aw)
   ) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .sld_i            (sld_i),
      .dw_wgt_start_i   (dw_wgt_start_i),
      .lane_mask_i      (lane_mask_i),
      .end_addr_i       (end_addr_i),
      .imem_r_addr_i    (imem_r_addr_i),
      .pe_data_v_i      (pe_data_v_i),
      .wgt_we_o         (wgt_we_o),
      .busy_o           (busy_o),
      .all_pe_ready_o   (all_pe_ready_o),
      .all_slave_done_o (all_slave_done_o),
      .run_cycles_o     (run_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] perf(input int n);
`ifdef BSG_MANYCORE_DRLP_PERF_EN
      return 32'(n);
`else
      return (n == n) ? 32'd0 : 32'd1;
`endif
   endfunction

   task automatic start(input logic [nl-1:0] m, input logic dw, input logic [aw-1:0] ea);
      sld_i = 1'b1; lane_mask_i = m; dw_wgt_start_i = dw; end_addr_i = ea;
      tick();
      sld_i = 1'b0;
   endtask

   initial begin
      reset_i = 1'b1; sld_i = 1'b0; dw_wgt_start_i = 1'b0; lane_mask_i = '0;
      end_addr_i = '0; imem_r_addr_i = '0; pe_data_v_i = '0;
      #12;
      chk("rst_wgt", 32'(wgt_we_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_ready", 32'(all_pe_ready_o), 32'h0);
      chk("rst_done", 32'(all_slave_done_o), 32'h0);
      chk("rst_perf", run_cycles_o, 32'h0);
      reset_i = 1'b0;
      tick();

      // Normal load, mask 1011; valids during LOAD must be ignored.
      start(4'b1011, 1'b0, 13'h40);
      pe_data_v_i = 4'b1111;
      chk("ld_we0", 32'(wgt_we_o), 32'h1);
      chk("ld_busy", 32'(busy_o), 32'h1);
      tick(); chk("ld_we1", 32'(wgt_we_o), 32'h2);
      tick(); chk("ld_we2", 32'(wgt_we_o), 32'h0);
      tick(); chk("ld_we3", 32'(wgt_we_o), 32'h8);
      tick();
      chk("run_we", 32'(wgt_we_o), 32'h0);
      chk("run_busy", 32'(busy_o), 32'h1);
      pe_data_v_i = 4'b0001; tick(); chk("rdy_a", 32'(all_pe_ready_o), 32'h0);
      pe_data_v_i = 4'b0100; tick(); chk("rdy_b", 32'(all_pe_ready_o), 32'h0);
      pe_data_v_i = 4'b0010; tick(); chk("rdy_c", 32'(all_pe_ready_o), 32'h0);
      pe_data_v_i = 4'b0100; tick(); chk("rdy_d", 32'(all_pe_ready_o), 32'h0);
      pe_data_v_i = 4'b1000; tick(); chk("rdy_e", 32'(all_pe_ready_o), 32'h1);
      pe_data_v_i = 4'b0000; imem_r_addr_i = 13'h3f;
      tick();
      chk("nomatch_done", 32'(all_slave_done_o), 32'h0);
      chk("nomatch_rdy", 32'(all_pe_ready_o), 32'h1);
      imem_r_addr_i = 13'h40;
      tick();
      chk("done", 32'(all_slave_done_o), 32'h1);
      chk("done_busy", 32'(busy_o), 32'h0);
      chk("done_rdy", 32'(all_pe_ready_o), 32'h0);
      chk("done_perf", run_cycles_o, perf(7));
      tick();
      chk("done_hold", 32'(all_slave_done_o), 32'h1);
      chk("done_perf_hold", run_cycles_o, perf(7));

      // Depthwise load from DONE.
      start(4'b1011, 1'b1, 13'h40);
      chk("dw_we", 32'(wgt_we_o), 32'hb);
      chk("dw_done_clr", 32'(all_slave_done_o), 32'h0);
      chk("dw_perf_clr", run_cycles_o, 32'h0);
      imem_r_addr_i = 13'h0;
      tick();
      chk("dw_run_we", 32'(wgt_we_o), 32'h0);
      chk("dw_run_busy", 32'(busy_o), 32'h1);
      for (int i = 0; i < 10; i++) tick();
      chk("perf10", run_cycles_o, perf(10));
      pe_data_v_i = 4'b1011; tick(); pe_data_v_i = 4'b0000;
      chk("dw_rdy", 32'(all_pe_ready_o), 32'h1);

      // Restart coinciding with completion: restart wins.
      imem_r_addr_i = 13'h40;
      start(4'b0001, 1'b0, 13'h40);
      chk("rs_we", 32'(wgt_we_o), 32'h1);
      chk("rs_rdy", 32'(all_pe_ready_o), 32'h0);
      chk("rs_done", 32'(all_slave_done_o), 32'h0);
      chk("rs_busy", 32'(busy_o), 32'h1);
      chk("rs_perf", run_cycles_o, 32'h0);
      tick(); chk("rs_we1", 32'(wgt_we_o), 32'h0);
      tick(); tick(); tick();
      pe_data_v_i = 4'b0001;
      tick(); pe_data_v_i = 4'b0000;
      chk("rs_rdy2", 32'(all_pe_ready_o), 32'h1);
      tick();
      chk("rs_done2", 32'(all_slave_done_o), 32'h1);

      // Asynchronous reset in the middle of a load.
      start(4'b1111, 1'b0, 13'h10);
      chk("ar_pre", 32'(wgt_we_o), 32'h1);
      #2 reset_i = 1'b1; #1;
      chk("ar_we", 32'(wgt_we_o), 32'h0);
      chk("ar_busy", 32'(busy_o), 32'h0);
      reset_i = 1'b0;
      tick();
      chk("ar_idle", 32'(busy_o), 32'h0);

      // Empty mask goes straight to DONE without strobes.
      start(4'b0000, 1'b0, 13'h10);
      chk("z_done", 32'(all_slave_done_o), 32'h1);
      chk("z_we", 32'(wgt_we_o), 32'h0);
      chk("z_busy", 32'(busy_o), 32'h0);
      tick();
      chk("z_we2", 32'(wgt_we_o), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
